// File: rtl/sonar_range_filter.sv
// Echo cycle count to millimetres with range rejection, moving average and proximity alarm.
// Define SONAR_MEDIAN3_EN to add a median-of-three stage on accepted readings (latency 4 instead of 3).
module sonar_range_filter #(
  parameter int CYC_WIDTH = 32,
  parameter int MM_WIDTH  = 16,
  parameter int SCALE     = 225,
  parameter int SHIFT     = 16,
  parameter int AVG_LOG2  = 2,
  parameter int MIN_MM    = 20,
  parameter int MAX_MM    = 4000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [CYC_WIDTH-1:0] in_cycles,
  input  logic                 clear,
  input  logic [MM_WIDTH-1:0]  alarm_thresh_mm,
  output logic                 out_valid,
  output logic [MM_WIDTH-1:0]  out_mm,
  output logic                 out_reject,
  output logic [MM_WIDTH-1:0]  out_avg_mm,
  output logic                 avg_ready,
  output logic                 alarm
);
  localparam int PROD_W = CYC_WIDTH + 8;
  localparam int SUM_W  = MM_WIDTH + AVG_LOG2;
  localparam int DEPTH  = 1 << AVG_LOG2;
  localparam logic [MM_WIDTH-1:0] MM_SAT = '1;
  localparam logic [AVG_LOG2:0]   FULL   = (AVG_LOG2+1)'(DEPTH);

  logic                v1;
  logic [PROD_W-1:0]   prod1;
  logic                v2;
  logic [MM_WIDTH-1:0] mm2;
  logic                rej2;
  logic [PROD_W-1:0]   mm_raw;
  logic [MM_WIDTH-1:0] mm_sat;
  logic                s3_valid;
  logic [MM_WIDTH-1:0] s3_mm;
  logic                s3_rej;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      prod1 <= '0;
    end else if (clear) begin
      v1 <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) prod1 <= PROD_W'(in_cycles) * PROD_W'(SCALE);
    end
  end

  always_comb begin
    mm_raw = prod1 >> SHIFT;
    mm_sat = (mm_raw > PROD_W'(MM_SAT)) ? MM_SAT : mm_raw[MM_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      mm2  <= '0;
      rej2 <= 1'b0;
    end else if (clear) begin
      v2 <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        mm2  <= mm_sat;
        rej2 <= (mm_sat < MM_WIDTH'(MIN_MM)) | (mm_sat > MM_WIDTH'(MAX_MM));
      end
    end
  end

`ifdef SONAR_MEDIAN3_EN
  logic                v2b;
  logic [MM_WIDTH-1:0] mm2b;
  logic                rej2b;
  logic [MM_WIDTH-1:0] hist0, hist1;
  logic [1:0]          hist_cnt;
  logic [MM_WIDTH-1:0] med;

  always_comb begin
    med = mm2;
    if ((hist0 <= hist1 && hist1 <= mm2) || (mm2 <= hist1 && hist1 <= hist0))
      med = hist1;
    else if ((hist1 <= hist0 && hist0 <= mm2) || (mm2 <= hist0 && hist0 <= hist1))
      med = hist0;
  end

  // History only tracks accepted readings; rejected ones pass through raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2b      <= 1'b0;
      mm2b     <= '0;
      rej2b    <= 1'b0;
      hist0    <= '0;
      hist1    <= '0;
      hist_cnt <= '0;
    end else if (clear) begin
      v2b      <= 1'b0;
      hist0    <= '0;
      hist1    <= '0;
      hist_cnt <= '0;
    end else begin
      v2b <= v2;
      if (v2) begin
        rej2b <= rej2;
        if (rej2) begin
          mm2b <= mm2;
        end else begin
          mm2b  <= (hist_cnt == 2'd2) ? med : mm2;
          hist1 <= hist0;
          hist0 <= mm2;
          if (hist_cnt != 2'd2) hist_cnt <= hist_cnt + 2'd1;
        end
      end
    end
  end

  assign s3_valid = v2b;
  assign s3_mm    = mm2b;
  assign s3_rej   = rej2b;
`else
  assign s3_valid = v2;
  assign s3_mm    = mm2;
  assign s3_rej   = rej2;
`endif

  logic [MM_WIDTH-1:0] win [DEPTH];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [SUM_W-1:0]    sum;
  logic [MM_WIDTH-1:0] oldest;
  logic [SUM_W-1:0]    sum_next;
  logic [AVG_LOG2:0]   fill_next;

  always_comb begin
    oldest    = (fill == FULL) ? win[wr_ptr] : '0;
    sum_next  = sum + SUM_W'(s3_mm) - SUM_W'(oldest);
    fill_next = (fill == FULL) ? fill : fill + (AVG_LOG2+1)'(1);
  end

  // clear outranks a coincident accepted write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_mm     <= '0;
      out_reject <= 1'b0;
      out_avg_mm <= '0;
      avg_ready  <= 1'b0;
      alarm      <= 1'b0;
      sum        <= '0;
      fill       <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else if (clear) begin
      out_valid  <= 1'b0;
      out_avg_mm <= '0;
      avg_ready  <= 1'b0;
      alarm      <= 1'b0;
      sum        <= '0;
      fill       <= '0;
      wr_ptr     <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      out_valid <= s3_valid;
      alarm     <= avg_ready & (out_avg_mm < alarm_thresh_mm);
      if (s3_valid) begin
        out_mm     <= s3_mm;
        out_reject <= s3_rej;
        if (!s3_rej) begin
          win[wr_ptr] <= s3_mm;
          wr_ptr      <= wr_ptr + AVG_LOG2'(1);
          sum         <= sum_next;
          fill        <= fill_next;
          if (fill_next == FULL) begin
            avg_ready  <= 1'b1;
            out_avg_mm <= MM_WIDTH'(sum_next >> AVG_LOG2);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sonar_range_filter.sv
// Scoreboard bench for sonar_range_filter: a reference model queues expected results per driven sample.
module tb_sonar_range_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_cycles = '0;
  logic        clear = 1'b0;
  logic [15:0] alarm_thresh_mm = '0;
  logic        out_valid;
  logic [15:0] out_mm;
  logic        out_reject;
  logic [15:0] out_avg_mm;
  logic        avg_ready;
  logic        alarm;

`ifdef SONAR_MEDIAN3_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  sonar_range_filter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_cycles(in_cycles),
    .clear(clear), .alarm_thresh_mm(alarm_thresh_mm), .out_valid(out_valid),
    .out_mm(out_mm), .out_reject(out_reject), .out_avg_mm(out_avg_mm),
    .avg_ready(avg_ready), .alarm(alarm)
  );

  always #10 clk = ~clk;

  typedef struct {
    int mm;
    bit rej;
    int avg;
    bit ready;
    int due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   win_m[4];
  int   wp_m, fill_m, sum_m, avg_m;
  bit   ready_m;
  int   h0, h1, hcnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) win_m[i] = 0;
    wp_m = 0; fill_m = 0; sum_m = 0; avg_m = 0; ready_m = 0;
    h0 = 0; h1 = 0; hcnt = 0;
    sb.delete();
  endtask

  function automatic int median3(input int a, input int b, input int c);
    int mx, mn;
    mx = (a > b) ? a : b; mx = (mx > c) ? mx : c;
    mn = (a < b) ? a : b; mn = (mn < c) ? mn : c;
    return a + b + c - mx - mn;
  endfunction

  // Drives one sample for a single cycle; called just after a rising edge.
  task automatic applyStimulus(input logic [31:0] c);
    longint unsigned p;
    exp_t e;
    int mm;
    p  = 64'(c) * 64'd225;
    p  = p >> 16;
    mm = (p > 64'd65535) ? 65535 : int'(p);
    e.rej = (mm < 20) || (mm > 4000);
    e.mm  = mm;
`ifdef SONAR_MEDIAN3_EN
    if (!e.rej) begin
      if (hcnt == 2) e.mm = median3(h0, h1, mm);
      h1 = h0; h0 = mm;
      if (hcnt < 2) hcnt++;
    end
`endif
    if (!e.rej) begin
      sum_m = sum_m + e.mm - ((fill_m == 4) ? win_m[wp_m] : 0);
      win_m[wp_m] = e.mm;
      wp_m = (wp_m + 1) % 4;
      if (fill_m < 4) fill_m++;
      if (fill_m == 4) begin
        ready_m = 1;
        avg_m = sum_m / 4;
      end
    end
    e.avg   = avg_m;
    e.ready = ready_m;
    e.due   = cyc + LAT;
    sb.push_back(e);
    in_valid  = 1'b1;
    in_cycles = c;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_out_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("latency_cycle", cyc, e.due);
        checkOutput("out_mm", out_mm, e.mm);
        checkOutput("out_reject", out_reject, e.rej);
        checkOutput("out_avg_mm", out_avg_mm, e.avg);
        checkOutput("avg_ready", avg_ready, e.ready);
      end
    end
  end

  initial begin
    resetModel();
    idle(3);
    rst_n = 1'b1;
    idle(1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_mm", out_mm, 0);
    checkOutput("reset_out_reject", out_reject, 0);
    checkOutput("reset_out_avg_mm", out_avg_mm, 0);
    checkOutput("reset_avg_ready", avg_ready, 0);
    checkOutput("reset_alarm", alarm, 0);

    applyStimulus(32'd291545);
    idle(5);
    applyStimulus(32'd0);
    applyStimulus(32'd2000000);
    applyStimulus(32'hFFFFFFFF);
    idle(6);

    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    resetModel();

    applyStimulus(32'd291545);
    applyStimulus(32'd582543);
    applyStimulus(32'd873814);
    applyStimulus(32'd1165085);
    applyStimulus(32'd291545);
    idle(6);
    checkOutput("avg_after_fifth", out_avg_mm, 2500);

    alarm_thresh_mm = 16'd3000;
    idle(1);
    checkOutput("alarm_thresh_3000", alarm, 1);
    alarm_thresh_mm = 16'd2000;
    idle(1);
    checkOutput("alarm_thresh_2000", alarm, 0);
    alarm_thresh_mm = 16'd3000;
    idle(1);
    checkOutput("alarm_before_clear", alarm, 1);

    // Two samples in flight plus one coincident with clear, all dropped.
    in_valid = 1'b1; in_cycles = 32'd582543;
    idle(1);
    in_cycles = 32'd873814;
    idle(1);
    in_cycles = 32'd291545;
    clear = 1'b1;
    idle(1);
    in_valid = 1'b0;
    clear = 1'b0;
    resetModel();
    checkOutput("clear_avg_ready", avg_ready, 0);
    checkOutput("clear_out_avg_mm", out_avg_mm, 0);
    checkOutput("clear_alarm", alarm, 0);
    idle(6);

    applyStimulus(32'd1165085);
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1);
    checkOutput("scoreboard_drained", sb.size(), 0);
    idle(2);
    checkOutput("post_clear_alarm", alarm, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sonar_range_filter.md
Name: sonar_range_filter

Overview:
- Downstream consumer of the ultrasonic echo-timer: takes each (valid, distance-in-cycles) result and converts it to millimetres at a 50 MHz clock.
- Rejects out-of-range readings and keeps a power-of-two moving average of accepted readings.
- Raises a proximity alarm from that average; the alarm and range outputs feed the control/display logic.

Parameters:
- CYC_WIDTH, 32: width of incoming cycle count.
- MM_WIDTH, 16: width of millimetre results; converted values saturate to 2^MM_WIDTH-1.
- SCALE, 225: fixed-point multiplier; mm = (cycles*SCALE) >> SHIFT, about 0.003433 mm/cycle at 343 m/s, round trip.
- SHIFT, 16: fixed-point shift.
- AVG_LOG2, 2: window depth is 2^AVG_LOG2 accepted samples.
- MIN_MM, 20: readings below this are rejected.
- MAX_MM, 4000: readings above this are rejected.

Ports:
- clk, input, 1: clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: one-cycle pulse; a new cycle count is present.
- in_cycles, input, CYC_WIDTH: echo duration in clock cycles.
- clear, input, 1: synchronous flush of window, pipeline and alarm.
- alarm_thresh_mm, input, MM_WIDTH: proximity threshold, sampled every cycle.
- out_valid, output, 1: one-cycle pulse per processed sample.
- out_mm, output, MM_WIDTH: converted, saturated distance of that sample.
- out_reject, output, 1: qualifies out_valid; sample was out of range.
- out_avg_mm, output, MM_WIDTH: window average.
- avg_ready, output, 1: window holds 2^AVG_LOG2 accepted samples.
- alarm, output, 1: level; avg_ready and out_avg_mm < alarm_thresh_mm.

Behaviour:
- Reset: all outputs 0, window contents/sum/fill count 0, pipeline valids 0. Reset mid-operation discards all in-flight samples.
- Pipeline of three registered stages, fully pipelined; in_valid may be asserted every cycle.
- S1: prod = in_cycles*SCALE, width CYC_WIDTH+8, no overflow.
- S2: mm_raw = prod >> SHIFT. If mm_raw exceeds 2^MM_WIDTH-1, mm = 2^MM_WIDTH-1. rej = (mm < MIN_MM) | (mm > MAX_MM).
- S3: out_valid=1, out_mm=mm, out_reject=rej, three cycles after in_valid.
- Accepted sample, at the S3 cycle:
  - Write to ring buffer at wr_ptr; wr_ptr wraps modulo 2^AVG_LOG2.
  - sum <= sum + mm - oldest, where oldest is the entry being overwritten (0 while filling). sum width MM_WIDTH+AVG_LOG2.
  - fill count increments, saturating at 2^AVG_LOG2.
- out_avg_mm = sum >> AVG_LOG2, registered, updated on the same edge as out_valid; holds 0 until avg_ready.
- avg_ready rises with the out_valid of the 2^AVG_LOG2-th accepted sample and stays high until clear/reset.
- Rejected samples: never enter the window; sum, avg and alarm unchanged.
- alarm: registered, recomputed every cycle from current out_avg_mm and alarm_thresh_mm. A threshold change takes effect the next cycle.
- clear: on the next edge, all stage valids, buffer, sum, fill count, wr_ptr, avg_ready, out_avg_mm and alarm go to 0.
  - Samples in flight are dropped; no out_valid is produced for them.
  - in_valid coincident with clear is also dropped.
  - clear has priority over any simultaneous S3 write.
- out_mm/out_reject hold their last values between pulses.

Optional Feature:
- SONAR_MEDIAN3_EN defined:
  - An extra stage S2b sits between S2 and S3 and replaces mm with the median of the last three accepted mm values, the current one included.
  - Until three accepted values exist, mm passes through unchanged.
  - Rejected samples bypass the median history; their raw mm is reported.
  - Latency becomes 4 cycles. clear/reset also empty the median history.
- Undefined: no median stage, latency 3 cycles.

Test Plan:
- Single sample: in_cycles=291545 → out_valid 3 cycles later, out_mm=1000, out_reject=0, avg_ready=0, out_avg_mm=0.
- Out-of-range: in_cycles=0 → out_mm=0, out_reject=1. in_cycles=2000000 → out_mm=6866, out_reject=1. Fill count unchanged in both cases.
- Saturation: in_cycles=32'hFFFFFFFF → out_mm=65535, out_reject=1.
- Window fill: back-to-back in_cycles 291545, 582543, 873814, 1165085 (1000/2000/3000/4000 mm).
  - Four consecutive out_valid pulses.
  - avg_ready rises with the 4th; out_avg_mm=2500.
  - A 5th sample of 1000 mm gives out_avg_mm=2500 (oldest 1000 replaced by 1000).
- Alarm: window full at 2500, alarm_thresh_mm=3000 → alarm=1 next cycle; thresh=2000 → alarm=0.
- clear: clear asserted with two samples in flight and window full → no further out_valid; avg_ready, out_avg_mm and alarm read 0 one cycle later. A subsequent sample is handled as the first after reset.
